l1_event_reader: RTL and testbench
==================================

L1_EVENT_READER -- requirements
Module: l1_event_reader

Interface
REQ-001 Parameter MAX_EVT, default 16, SHALL set the maximum number of events per packet; the legal range is 1..255.
REQ-002 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 enable  input  1  SHALL permit the start of a new packet when high.
REQ-005 fifo_empty  input  1  SHALL be the L1 event FIFO empty flag.
REQ-006 fifo_data  input  22  SHALL be the L1 event FIFO show-ahead head entry, valid whenever fifo_empty=0.
REQ-007 fifo_rd_en  output  1  SHALL be the FIFO pop strobe; one pop per asserted cycle.
REQ-008 out_data  output  32  SHALL be the packet word.
REQ-009 out_valid  output  1  SHALL indicate that out_data holds a word.
REQ-010 out_ready  input  1  SHALL be the downstream accept; a transfer occurs when out_valid=1 and out_ready=1.
REQ-011 out_last  output  1  SHALL mark the trailer word.
REQ-012 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-013 out_data, out_valid and out_last SHALL come from one output register; slot_free = !out_valid | out_ready.
REQ-014 The output register SHALL load only when slot_free=1; when nothing loads and out_ready=1, out_valid SHALL clear next cycle.
REQ-015 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-016 The FSM SHALL have the states IDLE and EVENT.
REQ-017 In IDLE, when enable=1, fifo_empty=0 and slot_free=1, the block SHALL load the header and go to EVENT; nevt and chk clear to 0.
REQ-018 Header word = {4'hA, 12'h000, seq[15:0]}.
REQ-019 In EVENT, when slot_free=1, fifo_empty=0 and nevt<MAX_EVT, the block SHALL load the event word {4'hE, 6'h00, fifo_data} and assert fifo_rd_en in that same cycle.
REQ-020 On each event load, nevt SHALL increment and chk SHALL be updated to chk ^ fifo_data[15:0].
REQ-021 In EVENT, when slot_free=1 and (fifo_empty=1 or nevt==MAX_EVT), the block SHALL load the trailer {4'hC, 4'h0, nevt[7:0], chk[15:0]} with out_last=1.
REQ-022 On the trailer load, seq SHALL increment and the FSM SHALL return to IDLE.
REQ-023 fifo_rd_en SHALL be combinational from state, slot_free and fifo_empty.
REQ-024 fifo_rd_en SHALL never be asserted when fifo_empty=1, in IDLE, or when slot_free=0.
REQ-025 seq SHALL be 16 bits and wrap from 0xFFFF to 0x0000; it is not reset by enable.
REQ-026 enable SHALL be sampled only in IDLE; deasserting it mid-packet SHALL NOT abort the packet, which completes normally.
REQ-027 A trailer with nevt=0 is legal (FIFO emptied externally) and SHALL be emitted as {4'hC,4'h0,8'h00,16'h0000}.
REQ-028 Back-to-back packets: the header of the next packet SHALL load no earlier than the cycle after the trailer loads.
REQ-029 Latency from fifo_empty falling in IDLE (enable=1, out_ready=1) to header out_valid SHALL be 1 cycle; the first event word follows 1 cycle after that.
REQ-030 Sustained throughput with out_ready=1 and a non-empty FIFO SHALL be one word per cycle, including one FIFO pop per event cycle.

Reset
REQ-031 While reset=1, the block SHALL set state=IDLE, seq=0, nevt=0, chk=0, out_valid=0, out_last=0, out_data=0, fifo_rd_en=0 and busy=0.
REQ-032 Reset asserted mid-packet SHALL discard the partial packet without emitting a trailer; no pop SHALL occur in the reset cycle.
REQ-033 reset SHALL take priority over all other inputs.

Verification
REQ-034 Single event: FIFO holds 22'h00ABCD, enable=1, out_ready=1 -> the bench sees 32'hA0000000, 32'hE000ABCD, 32'hC001ABCD (last=1), with exactly one fifo_rd_en pulse.
REQ-035 MAX_EVT=16 with 20 queued events -> packet 1 carries 16 events and a trailer with nevt=0x10; packet 2 has header seq=0x0001, carries 4 events and a trailer with nevt=0x04.
REQ-036 Backpressure: out_ready toggled randomly -> words are never lost or duplicated, out_data is stable while stalled, and the total pop count equals the number of event words.
REQ-037 enable dropped after the header -> the packet still completes with a trailer; no new header appears while enable=0 even if the FIFO is non-empty.
REQ-038 seq preset via 65536 packets -> the header after seq 0xFFFF carries 0x0000.
REQ-039 reset pulsed during the event stream -> out_valid=0 and busy=0 next cycle, no trailer, and the next header has seq=0x0000.

Source files
------------

// File: rtl/l1_event_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : l1_event_reader
// Function : Drains the L1 event FIFO into header / event / trailer packets.
// Revision : 1.0
// ============================================================================
module l1_event_reader #(
  parameter int MAX_EVT = 16  // legal range 1..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [21:0] fifo_data,
  output logic        fifo_rd_en,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy
);

  localparam logic [7:0] C_MAX_EVT = 8'(MAX_EVT);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_EVENT = 1'b1
  } state_t;

  state_t      state_q,     state_d;
  logic [15:0] seq_q,       seq_d;
  logic [7:0]  nevt_q,      nevt_d;
  logic [15:0] chk_q,       chk_d;
  logic [31:0] out_data_q,  out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q,  out_last_d;

  logic        slot_free;
  logic        rd_en;

  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    nevt_d      = nevt_q;
    chk_d       = chk_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    rd_en       = 1'b0;

    // A free slot means the held word has gone (or there was none); refill below.
    if (slot_free) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty && slot_free) begin
          out_data_d  = {4'hA, 12'h000, seq_q};
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          nevt_d      = 8'h00;
          chk_d       = 16'h0000;
          state_d     = ST_EVENT;
        end
      end

      ST_EVENT: begin
        if (slot_free) begin
          if (!fifo_empty && (nevt_q < C_MAX_EVT)) begin
            out_data_d  = {4'hE, 6'h00, fifo_data};
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            nevt_d      = nevt_q + 8'd1;
            chk_d       = chk_q ^ fifo_data[15:0];
            rd_en       = 1'b1;
          end else begin
            out_data_d  = {4'hC, 4'h0, nevt_q, chk_q};
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            seq_d       = seq_q + 16'd1;
            state_d     = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      seq_q       <= 16'h0000;
      nevt_q      <= 8'h00;
      chk_q       <= 16'h0000;
      out_data_q  <= 32'h0000_0000;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      nevt_q      <= nevt_d;
      chk_q       <= chk_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Reset masks the combinational outputs so no pop escapes in the reset cycle.
  assign fifo_rd_en = rd_en && !reset;
  assign busy       = (state_q != ST_IDLE) && !reset;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_l1_event_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_l1_event_reader
// Function : Scoreboard bench for l1_event_reader with a show-ahead FIFO model.
// Revision : 1.0
// ============================================================================
module tb_l1_event_reader;

  localparam int MAX_EVT = 16;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        enable     = 1'b0;
  logic        out_ready  = 1'b1;
  logic        fifo_flush = 1'b0;
  logic        fifo_empty;
  logic [21:0] fifo_data;
  logic        fifo_rd_en;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        busy;

  always #5 clk = ~clk;

  l1_event_reader #(.MAX_EVT(MAX_EVT)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy)
  );

  // Show-ahead FIFO model: reset or an external flush empties it.
  logic [21:0] fifo_mem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  int          pops   = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = fifo_mem[rd_ptr];

  always @(posedge clk) begin
    if (reset || fifo_flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && !fifo_empty) begin
      rd_ptr <= rd_ptr + 8'd1;
      pops   <= pops + 1;
    end
  end

  int          total    = 0;
  int          bad      = 0;
  int          xfer_cnt = 0;
  int          pop_base = 0;
  int          evt_seed = 1;
  logic [15:0] exp_seq  = 16'h0000;
  logic [32:0] exp_q [$];
  logic [21:0] pend  [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [32:0] prev_w;
    logic [32:0] exp_w;
    logic        prev_stall;
    prev_stall = 1'b0;
    prev_w     = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold", 64'({out_valid, out_last, out_data}), 64'({1'b1, prev_w}));
        end
        if (fifo_rd_en) begin
          check("rd_en_guard", 64'({fifo_empty, out_valid && !out_ready, !busy}), 64'(0));
        end
        if (out_valid && out_ready) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_word", 64'({out_last, out_data}), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            exp_w = exp_q.pop_front();
            check("word", 64'({out_last, out_data}), 64'(exp_w));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_w     = {out_last, out_data};
      end
    end
  endtask

  function automatic logic [21:0] evt_val(input int k);
    return 22'((k * 32'h0002_F1D3) ^ 32'h0001_5A5A);
  endfunction

  task automatic push_fifo(input logic [21:0] v);
    fifo_mem[wr_ptr] = v;
    wr_ptr           = wr_ptr + 8'd1;
  endtask

  task automatic queue_events(input int n);
    logic [21:0] v;
    for (int i = 0; i < n; i++) begin
      v = evt_val(evt_seed);
      evt_seed++;
      push_fifo(v);
      pend.push_back(v);
    end
  endtask

  // Splits pending events into MAX_EVT-sized packets of expected words.
  task automatic expect_pkts();
    int          n;
    logic [15:0] chk;
    logic [21:0] e;
    while (pend.size() > 0) begin
      n   = (pend.size() > MAX_EVT) ? MAX_EVT : pend.size();
      chk = 16'h0000;
      exp_q.push_back({1'b0, 4'hA, 12'h000, exp_seq});
      for (int i = 0; i < n; i++) begin
        e   = pend.pop_front();
        chk = chk ^ e[15:0];
        exp_q.push_back({1'b0, 4'hE, 6'h00, e});
      end
      exp_q.push_back({1'b1, 4'hC, 4'h0, 8'(n), chk});
      exp_seq = exp_seq + 16'd1;
    end
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !busy && !out_valid) done = 1'b1;
    end
    check({name, "_drain"}, 64'(done), 64'(1));
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check("reset_rd_busy", 64'({fifo_rd_en, busy}), 64'(0));
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    check("reset_outputs", 64'({out_valid, out_last, busy, fifo_rd_en, out_data}), 64'(0));
    exp_q.delete();
    pend.delete();
    exp_seq  = 16'h0000;
    pop_base = pops;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    bit hit;
    fork
      monitor();
    join_none

    // Reset with enable high and a queued entry: reset must win.
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push_fifo(22'h3FFFFF);
    do_reset();

    // Single event with the literal expected packet, plus header latency.
    push_fifo(22'h00ABCD);
    exp_q.push_back({1'b0, 32'hA000_0000});
    exp_q.push_back({1'b0, 32'hE000_ABCD});
    exp_q.push_back({1'b1, 32'hC001_ABCD});
    exp_seq = exp_seq + 16'd1;
    @(posedge clk);
    #1;
    check("hdr_latency", 64'({out_valid, out_data}), 64'({1'b1, 32'hA000_0000}));
    @(posedge clk);
    #1;
    check("evt_latency", 64'({out_valid, fifo_rd_en, out_data}), 64'({2'b10, 32'hE000_ABCD}));
    wait_idle("single");
    check("single_pops", 64'(pops - pop_base), 64'(1));
    pop_base = pops;

    // Zero-event packet: FIFO emptied externally right after the header loads.
    push_fifo(22'h012345);
    fifo_flush = 1'b1;
    exp_q.push_back({1'b0, 32'hA000_0001});
    exp_q.push_back({1'b1, 32'hC000_0000});
    exp_seq = exp_seq + 16'd1;
    @(posedge clk);
    #1;
    fifo_flush = 1'b0;
    wait_idle("zero_evt");
    check("zero_evt_pops", 64'(pops - pop_base), 64'(0));

    // 20 events split over two packets by MAX_EVT.
    do_reset();
    queue_events(20);
    expect_pkts();
    wait_idle("max_evt");
    check("max_evt_pops", 64'(pops - pop_base), 64'(20));
    pop_base = pops;

    // Random backpressure.
    queue_events(10);
    expect_pkts();
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(posedge clk);
      #1;
      out_ready = 1'($urandom_range(0, 1));
      if (exp_q.size() == 0 && !busy && !out_valid) hit = 1'b1;
    end
    out_ready = 1'b1;
    wait_idle("backpressure");
    check("backpressure_pops", 64'(pops - pop_base), 64'(10));
    pop_base = pops;

    // Enable dropped right after the header: packet still completes.
    queue_events(3);
    expect_pkts();
    @(posedge clk);
    #1;
    enable = 1'b0;
    check("enable_drop_busy", 64'(busy), 64'(1));
    wait_idle("enable_drop");
    queue_events(2);
    repeat (10) @(posedge clk);
    #1;
    check("no_hdr_disabled", 64'({busy, out_valid, fifo_empty}), 64'(0));
    enable = 1'b1;
    expect_pkts();
    wait_idle("enable_resume");
    check("enable_pops", 64'(pops - pop_base), 64'(5));
    pop_base = pops;

    // Sequence wrap from 0xFFFF to 0x0000.
    force dut.seq_q = 16'hFFFF;
    @(negedge clk);
    release dut.seq_q;
    @(posedge clk);
    #1;
    exp_seq = 16'hFFFF;
    queue_events(1);
    expect_pkts();
    wait_idle("seq_ffff");
    queue_events(1);
    expect_pkts();
    wait_idle("seq_wrap");
    check("seq_wrap_model", 64'(exp_seq), 64'(16'h0001));

    // Reset in the middle of the event stream.
    queue_events(12);
    expect_pkts();
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (xfer_cnt >= 4 && busy) hit = 1'b1;
    end
    check("mid_reset_reached", 64'(hit), 64'(1));
    do_reset();
    repeat (6) @(posedge clk);
    #1;
    check("mid_reset_quiet", 64'({out_valid, busy}), 64'(0));
    queue_events(1);
    expect_pkts();
    @(posedge clk);
    #1;
    check("post_reset_hdr", 64'({out_valid, out_data}), 64'({1'b1, 32'hA000_0000}));
    wait_idle("post_reset");
    check("post_reset_pops", 64'(pops - pop_base), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
